mem: RTL and testbench

Dual-port synchronous 32×8 memory with one `mem_intf` bus per port. `mbus` and `m2bus` share a single storage array, and both ports are fully independent for reads and writes. The block sits under `top` next to the `mem_test` stimulus block. All signalling goes through `mem_intf` modports: `mem` on the DUT side, `tb` on the bench side.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_intf.sv | 75 +++++++
 rtl/mem.sv | 70 +++++++
 tb/tb_mem.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and typedefs for the dual-port memory slice.
//   ADDR_WIDTH - word address width
//   DATA_WIDTH - data word width
//   DEPTH      - number of words (2**ADDR_WIDTH)
//   addr_t     - word address type
//   data_t     - data word type
package mem_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : mem_pkg

// File: rtl/mem_intf.sv
// mem_intf: one memory port bus.
//   clk      - port-list input, the sole clock
//   rst_n    - asynchronous active-low reset, driven from the tb side
//   read     - read strobe
//   write    - write strobe
//   addr     - word address
//   data_in  - write data
//   data_out - registered read data from the memory
//
// Handshake: a strobe is a single-cycle request. The requester drives
// read/write/addr/data_in after a falling edge, the memory samples them on
// the next rising edge, and read data is valid from that rising edge until
// the next read on the same port. read and write together is illegal and
// is ignored by the memory. There is no back-pressure.
//
// The tb-side tasks expect to be called right after a falling edge; each
// one occupies exactly one clock, so calls can be issued back to back.
interface mem_intf
  import mem_pkg::*;
(
  input logic clk
);

  logic  rst_n;
  logic  read;
  logic  write;
  addr_t addr;
  data_t data_in;
  data_t data_out;

  modport mem (
    input  clk,
    input  rst_n,
    input  read,
    input  write,
    input  addr,
    input  data_in,
    output data_out
  );

  modport tb (
    input  clk,
    input  data_out,
    output rst_n,
    output read,
    output write,
    output addr,
    output data_in,
    import write_mem,
    import read_mem
  );

  // One-cycle write: drive now, the rising edge commits, drop the strobe
  // on the following falling edge.
  task automatic write_mem(input addr_t a, input data_t d);
    write   = 1'b1;
    read    = 1'b0;
    addr    = a;
    data_in = d;
    @(negedge clk);
    write   = 1'b0;
  endtask

  // One-cycle read: drive now, the rising edge captures, sample the
  // registered data on the following falling edge.
  task automatic read_mem(input addr_t a, output data_t d);
    read  = 1'b1;
    write = 1'b0;
    addr  = a;
    @(negedge clk);
    read  = 1'b0;
    d     = data_out;
  endtask

endinterface : mem_intf

// File: rtl/mem.sv
// mem: dual-port synchronous 32x8 memory with a single shared storage array.
//   mbus  - port A bus (mem_intf.mem); its clk is the memory clock
//   m2bus - port B bus (mem_intf.mem)
// Both ports can read or write independently every cycle. Reads are
// registered (one-cycle latency) and return the contents before any write
// in the same cycle. On a same-address double write, port A wins. Reset
// (either bus rst_n low) clears storage and both read registers
// asynchronously.
module mem
  import mem_pkg::*;
(
  mem_intf.mem mbus,
  mem_intf.mem m2bus
);

  data_t mem_q [DEPTH];
  data_t a_dout_q;
  data_t b_dout_q;
  logic  rst_n;
  logic  a_we;
  logic  a_re;
  logic  b_we;
  logic  b_re;

  // Both buses carry the same reset from the bench; combining them keeps
  // the memory in reset if either side asserts it.
  assign rst_n = mbus.rst_n & m2bus.rst_n;

  // read+write together qualifies neither strobe.
  assign a_we = mbus.write  & ~mbus.read;
  assign a_re = mbus.read   & ~mbus.write;
  assign b_we = m2bus.write & ~m2bus.read;
  assign b_re = m2bus.read  & ~m2bus.write;

  // Storage. Port B's update is scheduled first so that port A's update,
  // scheduled later in the same block, overrides it on an address clash.
  always_ff @(posedge mbus.clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (b_we) mem_q[m2bus.addr] <= m2bus.data_in;
      if (a_we) mem_q[mbus.addr]  <= mbus.data_in;
    end
  end

  // Port A read register. Sampling mem_q here sees the pre-write value,
  // which gives read-before-write against the other port.
  always_ff @(posedge mbus.clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout_q <= '0;
    end else if (a_re) begin
      a_dout_q <= mem_q[mbus.addr];
    end
  end

  // Port B read register.
  always_ff @(posedge mbus.clk or negedge rst_n) begin
    if (!rst_n) begin
      b_dout_q <= '0;
    end else if (b_re) begin
      b_dout_q <= mem_q[m2bus.addr];
    end
  end

  assign mbus.data_out  = a_dout_q;
  assign m2bus.data_out = b_dout_q;

endmodule : mem

// File: tb/tb_mem.sv
// tb_mem: self-checking bench for the dual-port memory.
module tb_mem;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_intf bus_a (clk);
  mem_intf bus_b (clk);

  mem dut (
    .mbus  (bus_a),
    .m2bus (bus_b)
  );

  // ---------------- scoreboard ----------------
  int    checks   = 0;
  int    failures = 0;
  data_t exp_q[$];

  typedef struct {
    bit    port;    // 0 = A (mbus), 1 = B (m2bus)
    bit    is_wr;
    addr_t addr;
    data_t data;    // write data
    data_t exp;     // expected read data
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int idx, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %02h expected %02h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input bit port, input addr_t a, input data_t d);
    if (port == 1'b0) bus_a.write_mem(a, d);
    else              bus_b.write_mem(a, d);
  endtask

  task automatic rd_chk(input bit port, input addr_t a, input data_t exp,
                        input string name, input int idx);
    data_t got;
    data_t e;
    exp_q.push_back(exp);
    if (port == 1'b0) bus_a.read_mem(a, got);
    else              bus_b.read_mem(a, got);
    e = exp_q.pop_front();
    check(name, idx, got, e);
  endtask

  task automatic set_reset(input logic v);
    bus_a.rst_n = v;
    bus_b.rst_n = v;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test body ----------------
  initial begin
    data_t got_b;
    data_t e;

    tbl[0] = '{1'b0, 1'b1, 5'd9,  8'h44, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 5'd3,  8'h11, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 5'd7,  8'h33, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 5'd9,  8'h00, 8'h44};
    tbl[4] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'h11};
    tbl[5] = '{1'b1, 1'b0, 5'd7,  8'h00, 8'h33};
    tbl[6] = '{1'b1, 1'b1, 5'd20, 8'hC3, 8'h00};
    tbl[7] = '{1'b0, 1'b0, 5'd20, 8'h00, 8'hC3};
    tbl[8] = '{1'b0, 1'b0, 5'd21, 8'h00, 8'h15};
    tbl[9] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h00};

    bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.addr = '0; bus_a.data_in = '0;
    bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.addr = '0; bus_b.data_in = '0;
    set_reset(1'b0);
    #1;
    check("init_rst_a", 0, bus_a.data_out, 8'h00);
    check("init_rst_b", 0, bus_b.data_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    set_reset(1'b1);
    @(negedge clk);

    // Address sweep: A writes i with i, B reads it back.
    for (int i = 0; i < DEPTH; i++) wr(1'b0, addr_t'(i), data_t'(i));
    for (int i = 0; i < DEPTH; i++) rd_chk(1'b1, addr_t'(i), data_t'(i), "sweep_b", i);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].port, tbl[i].addr, tbl[i].data);
      else rd_chk(tbl[i].port, tbl[i].addr, tbl[i].exp, "table", i);
    end

    // Write collision on address 5: port A must win.
    fork
      bus_a.write_mem(5'd5, 8'hAA);
      bus_b.write_mem(5'd5, 8'h55);
    join
    rd_chk(1'b0, 5'd5, 8'hAA, "wcol_a", 0);
    rd_chk(1'b1, 5'd5, 8'hAA, "wcol_b", 0);

    // Read/write collision on address 3 (holds 8'h11): B sees old data.
    exp_q.push_back(8'h11);
    fork
      bus_a.write_mem(5'd3, 8'h22);
      bus_b.read_mem(5'd3, got_b);
    join
    e = exp_q.pop_front();
    check("rwcol_old", 0, got_b, e);
    rd_chk(1'b1, 5'd3, 8'h22, "rwcol_new", 0);

    // Illegal read+write at 7 (holds 8'h33): no write, data_out holds.
    rd_chk(1'b0, 5'd9, 8'h44, "illegal_pre", 0);
    bus_a.read = 1'b1; bus_a.write = 1'b1; bus_a.addr = 5'd7; bus_a.data_in = 8'hFF;
    @(negedge clk);
    bus_a.read = 1'b0; bus_a.write = 1'b0;
    check("illegal_hold", 0, bus_a.data_out, 8'h44);
    rd_chk(1'b1, 5'd7, 8'h33, "illegal_mem_b", 0);
    rd_chk(1'b0, 5'd7, 8'h33, "illegal_mem_a", 0);

    // Hold: read 9 then idle for three cycles.
    rd_chk(1'b0, 5'd9, 8'h44, "hold_rd", 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_idle", i, bus_a.data_out, 8'h44);
    end

    // Mid-run reset with a write and a read in flight.
    bus_a.write = 1'b1; bus_a.read = 1'b0; bus_a.addr = 5'd10; bus_a.data_in = 8'hEE;
    bus_b.read  = 1'b1; bus_b.write = 1'b0; bus_b.addr = 5'd9;
    #2;
    set_reset(1'b0);
    #1;
    check("rst_async_a", 0, bus_a.data_out, 8'h00);
    check("rst_async_b", 0, bus_b.data_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("rst_held_a", 0, bus_a.data_out, 8'h00);
    check("rst_held_b", 0, bus_b.data_out, 8'h00);
    bus_a.write = 1'b0;
    bus_b.read  = 1'b0;
    set_reset(1'b1);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) rd_chk(1'b0, addr_t'(i), 8'h00, "rst_clr_a", i);
    for (int i = 0; i < DEPTH; i++) rd_chk(1'b1, addr_t'(i), 8'h00, "rst_clr_b", i);

    // Operation resumes after reset; random spot values.
    for (int i = 0; i < 4; i++) begin
      addr_t a;
      data_t d;
      a = addr_t'($urandom_range(0, DEPTH - 1));
      d = data_t'($urandom_range(1, 255));
      wr(1'b1, a, d);
      rd_chk(1'b0, a, d, "post_rst", i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem
